counter_scheduler: RTL and testbench

Arbitrated command front-end for the shared W-bit up/down counter. Up to N requesters each ask for a single increment or decrement; the block grants one request at a time (round-robin), drives the counter's 2-bit `ctrl` input for exactly one cycle per granted operation, and refuses (NAKs) any operation that would cross a programmed bound. The block sits between requesting agents and the counter instance; it reads back the counter's `count` output to make bound decisions, so the counter itself never wraps.

---
 rtl/counter_scheduler_if.sv | 16 +
 rtl/counter_scheduler.sv | 76 +++++++
 tb/tb_counter_scheduler.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/counter_scheduler_if.sv
// counter_scheduler_if: requester-side bundle between the agents and the counter scheduler
//   req  : per-requester request level
//   dir  : per-requester direction, 0 = increment, 1 = decrement
//   gnt  : one-hot pulse, the request was executed
//   nak  : one-hot pulse, the request was refused at a bound
//   master modport faces the requesters, slave modport faces the scheduler
interface counter_scheduler_if #(
    parameter int N = 4
);
    logic [N-1:0] req;
    logic [N-1:0] dir;
    logic [N-1:0] gnt;
    logic [N-1:0] nak;
    modport master (output req, dir, input gnt, nak);
    modport slave (input req, dir, output gnt, nak);
endinterface

// File: rtl/counter_scheduler.sv
// counter_scheduler: round-robin front-end issuing bounded inc/dec commands to a shared counter
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : counter_scheduler_if.slave (req, dir in; gnt, nak out)
//   count_in : current counter value, used for bound decisions
//   ctrl     : counter command, 00 hold, 01 increment, 10 decrement
//   busy     : high whenever not idle
//   Optional macro COUNTER_SCHED_PRIO_EN: requester 0 gets absolute priority
module counter_scheduler #(
    parameter int N = 4,
    parameter int W = 8,
    parameter logic [W-1:0] HI_LIMIT = {W{1'b1}},
    parameter logic [W-1:0] LO_LIMIT = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    counter_scheduler_if.slave  bus,
    input  logic [W-1:0]        count_in,
    output logic [1:0]          ctrl,
    output logic                busy
);
    localparam int PW = $clog2(N);
    typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;
    state_t state, state_nx;
    logic [PW-1:0] ptr, ptr_nx, win;
    logic [N-1:0] gnt_nx, nak_nx;
    logic [1:0] ctrl_nx;
    logic allow;
    // first requesting index scanning from ptr, wrapping modulo N
    always_comb begin
        win = ptr;
        for (int i = N - 1; i >= 0; i--)
            if (bus.req[PW'((int'(ptr) + i) % N)]) win = PW'((int'(ptr) + i) % N);
`ifdef COUNTER_SCHED_PRIO_EN
        if (bus.req[0]) win = '0;
`endif
    end
    assign allow = bus.dir[win] ? (count_in > LO_LIMIT) : (count_in < HI_LIMIT);
    always_comb begin
        state_nx = IDLE;
        ptr_nx = ptr;
        gnt_nx = '0;
        nak_nx = '0;
        ctrl_nx = 2'b00;
        if (state == ISSUE) begin
            state_nx = SETTLE;
        end else if (|bus.req) begin
            state_nx = ISSUE;
            gnt_nx[win] = allow;
            nak_nx[win] = !allow;
            ctrl_nx = allow ? (bus.dir[win] ? 2'b10 : 2'b01) : 2'b00;
            ptr_nx = (win == PW'(N - 1)) ? '0 : win + 1'b1;
`ifdef COUNTER_SCHED_PRIO_EN
            // a priority win by requester 0 leaves the rotation of 1..N-1 untouched
            if (bus.req[0]) ptr_nx = ptr;
`endif
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr <= '0;
            bus.gnt <= '0;
            bus.nak <= '0;
            ctrl <= 2'b00;
            busy <= 1'b0;
        end else begin
            state <= state_nx;
            ptr <= ptr_nx;
            bus.gnt <= gnt_nx;
            bus.nak <= nak_nx;
            ctrl <= ctrl_nx;
            busy <= state_nx != IDLE;
        end
    end
endmodule

// File: tb/tb_counter_scheduler.sv
// tb_counter_scheduler: scoreboard bench with an attached counter and a batch-level reference model
module tb_counter_scheduler;
    localparam int N = 4;
    localparam int W = 8;
    localparam logic [W-1:0] HI = 8'd250;
    localparam logic [W-1:0] LO = 8'd3;
    typedef struct packed {
        logic [N-1:0] gnt;
        logic [N-1:0] nak;
        logic [1:0]   ctrl;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [W-1:0] cnt = '0;
    logic [W-1:0] preset_val = '0;
    logic preset_en = 1'b0;
    logic [1:0] ctrl;
    logic busy;
    logic [1:0] ctrl_prev = 2'b00;
    int tests = 0;
    int fails = 0;
    exp_t sbq[$];
    exp_t mon_e;
    int mptr = 0;
    logic [W-1:0] mcnt = '0;
    logic [W-1:0] edges [8] = '{8'd0, 8'd2, 8'd3, 8'd4, 8'd249, 8'd250, 8'd251, 8'd255};

    counter_scheduler_if #(.N(N)) bus();
    counter_scheduler #(.N(N), .W(W), .HI_LIMIT(HI), .LO_LIMIT(LO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .count_in(cnt), .ctrl(ctrl), .busy(busy)
    );

    always #5 clk = ~clk;

    // the shared counter being commanded
    always @(posedge clk)
        cnt <= preset_en ? preset_val : (ctrl == 2'b01) ? cnt + 1'b1 : (ctrl == 2'b10) ? cnt - 1'b1 : cnt;

    task automatic check(string name, logic [31:0] act, logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (|(bus.gnt | bus.nak)) begin
                if (sbq.size() == 0) begin
                    check("unexpected_pulse", {bus.gnt, bus.nak}, 0);
                end else begin
                    mon_e = sbq.pop_front();
                    check("gnt", bus.gnt, mon_e.gnt);
                    check("nak", bus.nak, mon_e.nak);
                    check("ctrl", ctrl, mon_e.ctrl);
                end
            end else begin
                check("quiet_ctrl", ctrl, 0);
            end
            if (ctrl != 2'b00) check("ctrl_back_to_back", ctrl_prev, 0);
            ctrl_prev <= ctrl;
        end
    end

    // All requesters in the mask are pending together, so they are served in
    // cyclic order from the pointer; each decision uses the running count.
    task automatic start_batch(logic [N-1:0] mask, logic [N-1:0] dirs);
        logic [N-1:0] m;
        exp_t e;
        int w;
        bit ok;
        m = mask;
        while (m != '0) begin
            w = -1;
`ifdef COUNTER_SCHED_PRIO_EN
            if (m[0]) w = 0;
`endif
            for (int k = 0; k < N; k++)
                if (w < 0 && m[(mptr + k) % N]) w = (mptr + k) % N;
            ok = dirs[w] ? (mcnt > LO) : (mcnt < HI);
            e.gnt = ok ? N'(1) << w : '0;
            e.nak = ok ? '0 : N'(1) << w;
            e.ctrl = ok ? (dirs[w] ? 2'b10 : 2'b01) : 2'b00;
            sbq.push_back(e);
            if (ok) mcnt = dirs[w] ? mcnt - 1'b1 : mcnt + 1'b1;
`ifdef COUNTER_SCHED_PRIO_EN
            if (w != 0) mptr = (w + 1) % N;
`else
            mptr = (w + 1) % N;
`endif
            m[w] = 1'b0;
        end
        @(negedge clk);
        bus.dir = dirs;
        bus.req = mask;
    endtask

    task automatic drain();
        int cyc;
        int last;
        bit done;
        cyc = 0;
        last = -1;
        done = 1'b0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (|(bus.gnt | bus.nak)) begin
                if (last >= 0) check("service_gap", cyc - last, 2);
                last = cyc;
                bus.req = bus.req & ~(bus.gnt | bus.nak);
            end
            done = (bus.req == '0) && !busy;
        end
        if (!done) check("drain_timeout", cyc, 0);
        check("count_final", cnt, mcnt);
        check("scoreboard_empty", sbq.size(), 0);
    endtask

    task automatic preset(logic [W-1:0] v);
        @(negedge clk);
        preset_en = 1'b1;
        preset_val = v;
        @(negedge clk);
        preset_en = 1'b0;
        mcnt = v;
    endtask

    initial begin
        int pk;
        logic [N-1:0] rm;
        bus.req = '0;
        bus.dir = '0;
        repeat (2) @(negedge clk);
        check("rst_ctrl", ctrl, 0);
        check("rst_gnt", bus.gnt, 0);
        check("rst_nak", bus.nak, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;

        preset(8'd5);
        start_batch(4'b0001, 4'b0000);
        @(negedge clk);
        check("single_busy", busy, 1);
        check("single_ctrl", ctrl, 1);
        bus.req = '0;
        @(negedge clk);
        check("settle_busy", busy, 1);
        check("settle_count", cnt, 6);
        @(negedge clk);
        check("idle_busy", busy, 0);
        drain();

        preset(8'd100);
        start_batch(4'b1111, 4'b0101);
        drain();

        preset(HI);
        start_batch(4'b0010, 4'b0000);
        drain();
        start_batch(4'b0100, 4'b0100);
        drain();
        preset(8'd255);
        start_batch(4'b0110, 4'b0100);
        drain();

        preset(LO);
        start_batch(4'b0001, 4'b0001);
        drain();
        preset(LO - 1'b1);
        start_batch(4'b0011, 4'b0010);
        drain();
        preset(8'd0);
        start_batch(4'b1001, 4'b1001);
        drain();

        for (int it = 0; it < 40; it++) begin
            pk = $urandom_range(0, 11);
            preset(pk < 8 ? edges[pk] : W'($urandom_range(0, 255)));
            rm = N'($urandom_range(1, 15));
            start_batch(rm, N'($urandom));
            drain();
        end

        preset(8'd5);
        @(negedge clk);
        bus.dir = '0;
        bus.req = 4'b0001;
        @(posedge clk);
        #2;
        check("pre_reset_ctrl", ctrl, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_ctrl", ctrl, 0);
        check("async_rst_gnt", bus.gnt, 0);
        check("async_rst_nak", bus.nak, 0);
        check("async_rst_busy", busy, 0);
        bus.req = '0;
        repeat (2) @(negedge clk);
        check("rst_hold_count", cnt, 5);
        rst_n = 1'b1;
        mptr = 0;
        start_batch(4'b0101, 4'b0000);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
